// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus port buffers: device ids, destination
// extraction and the occupancy-counter width.
package bus_pkg;

  typedef logic [7:0] dev_id_t;

  localparam dev_id_t BROADCAST_ID  = 8'hFF;
  localparam int      PKT_MAX_W     = 64;
  localparam int      DEFAULT_DEPTH = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEFAULT_DEPTH);

  // Destination id lives in the top byte of a pckg_sz-wide packet.
  function automatic dev_id_t dest_of(input logic [PKT_MAX_W-1:0] pkt, input int pckg_sz);
    return dev_id_t'(pkt >> (pckg_sz - 8));
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count and
// single-cycle pulses for writes dropped on full and reads ignored on empty.
module sync_fifo_fwft
  import bus_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic [cnt_w(depth)-1:0]  count,
  output logic                     full,
  output logic                     empty,
  output logic                     wr_drop,
  output logic                     rd_drop
);

  localparam int PW = $clog2(depth);
  localparam int CW = cnt_w(depth);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Strobes are single-cycle requests; wr is taken when space exists or a
  // read frees the head in the same cycle, rd is taken whenever non-empty.
  assign empty   = (count == '0);
  assign full    = (count == CW'(depth));
  assign rd_ok   = rd && !empty;
  assign wr_ok   = wr && (!full || rd);
  assign wr_drop = wr && full && !rd;
  assign rd_drop = rd && empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // Storage is deliberately left out of reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_port_fifo.sv
// Per-device port buffer: TX FIFO toward the bus arbiter, RX FIFO from it,
// plus sticky error flags, destination check and an RX drop counter.
module bus_port_fifo
  import bus_pkg::*;
#(
  parameter int      pckg_sz   = 16,
  parameter int      depth     = 8,
  parameter dev_id_t id        = 8'h00,
  parameter dev_id_t broadcast = BROADCAST_ID
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tx_wr,
  input  logic [pckg_sz-1:0]       tx_data,
  output logic                     tx_full,
  output logic [cnt_w(depth)-1:0]  tx_count,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  input  logic                     rx_rd,
  output logic [pckg_sz-1:0]       rx_data,
  output logic                     rx_vld,
  output logic [cnt_w(depth)-1:0]  rx_count,
  output logic                     tx_ovf,
  output logic                     rx_ovf,
  output logic                     pop_err,
  output logic                     addr_err,
  output logic [7:0]               rx_drop_cnt,
  input  logic                     err_clr
);

  logic    tx_empty, tx_wr_drop, tx_rd_drop;
  logic    rx_empty, rx_full, rx_wr_drop, rx_rd_drop;
  logic    rx_accept, bad_dest;
  dev_id_t dest;
  logic [1:0] rx_unused;

  sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_wr),
    .rd      (pop),
    .din     (tx_data),
    .dout    (D_pop),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty),
    .wr_drop (tx_wr_drop),
    .rd_drop (tx_rd_drop)
  );

  sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr      (push),
    .rd      (rx_rd),
    .din     (D_push),
    .dout    (rx_data),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty),
    .wr_drop (rx_wr_drop),
    .rd_drop (rx_rd_drop)
  );

  // Host reads on an empty RX FIFO are harmless and raise nothing.
  assign rx_unused = {rx_full, rx_rd_drop};

  assign pndng     = !tx_empty;
  assign rx_vld    = !rx_empty;
  assign rx_accept = push && !rx_wr_drop;
  assign dest      = dest_of(PKT_MAX_W'(D_push), pckg_sz);
  assign bad_dest  = (dest != id) && (dest != broadcast);

  // err_clr wins over any same-cycle set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf      <= 1'b0;
      rx_ovf      <= 1'b0;
      pop_err     <= 1'b0;
      addr_err    <= 1'b0;
      rx_drop_cnt <= '0;
    end else if (err_clr) begin
      tx_ovf      <= 1'b0;
      rx_ovf      <= 1'b0;
      pop_err     <= 1'b0;
      addr_err    <= 1'b0;
      rx_drop_cnt <= '0;
    end else begin
      if (tx_wr_drop)             tx_ovf   <= 1'b1;
      if (rx_wr_drop)             rx_ovf   <= 1'b1;
      if (tx_rd_drop)             pop_err  <= 1'b1;
      if (rx_accept && bad_dest)  addr_err <= 1'b1;
      if (rx_wr_drop && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 8'd1;
    end
  end

endmodule

// File: doc/bus_port_fifo.md
Name: bus_port_fifo

Overview:
- Per-device port buffer that sits directly against one port of bs_gnrtr_n_rbtr.
- TX side: the host writes packets; the block presents pndng/D_pop to the bus and dequeues on pop.
- RX side: the block captures D_push on push from the bus and the host drains it.
- One instance per device (drvrs instances), each tagged with its own id. It checks the destination field of received packets.

Parameters:
- pckg_sz, 16, packet width in bits; the destination id occupies bits [pckg_sz-1 -: 8].
- depth, 8, entries per FIFO (TX and RX each); power of two, >= 2.
- id, 0, this port's 8-bit device id.
- broadcast, 8'hFF, broadcast destination id.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_wr  in  1  host write strobe for the TX FIFO.
- tx_data  in  pckg_sz  host packet to transmit.
- tx_full  out  1  TX FIFO full.
- tx_count  out  $clog2(depth+1)  TX occupancy.
- pndng  out  1  to bus: TX FIFO non-empty.
- D_pop  out  pckg_sz  to bus: TX head packet (first-word fall-through).
- pop  in  1  from bus: dequeue TX head.
- push  in  1  from bus: D_push is valid, enqueue to RX.
- D_push  in  pckg_sz  from bus: delivered packet.
- rx_rd  in  1  host read strobe for the RX FIFO.
- rx_data  out  pckg_sz  RX head packet (FWFT).
- rx_vld  out  1  RX FIFO non-empty.
- rx_count  out  $clog2(depth+1)  RX occupancy.
- tx_ovf  out  1  sticky: host wrote while TX was full.
- rx_ovf  out  1  sticky: bus pushed while RX was full.
- pop_err  out  1  sticky: pop asserted while TX was empty.
- addr_err  out  1  sticky: accepted packet whose destination is neither id nor broadcast.
- rx_drop_cnt  out  8  count of RX packets dropped on full; saturates at 255.
- err_clr  in  1  synchronous clear of all sticky flags and rx_drop_cnt.

Behaviour:
- Reset, asynchronous and active-high: pointers 0, counts 0, pndng=0, rx_vld=0, tx_full=0, all sticky flags 0, rx_drop_cnt=0. D_pop and rx_data read 0 while empty; storage itself is not cleared.
- Reset mid-operation: all in-flight contents are discarded immediately. pndng drops in the same cycle, combinationally from the cleared count.
- FWFT: D_pop = TX head whenever pndng=1. A written entry appears on D_pop/pndng one cycle after the tx_wr edge (write latency 1); same for push -> rx_vld/rx_data.
- pndng = (tx_count != 0); tx_full = (tx_count == depth). Same relations on the RX side.
- TX write: tx_wr && !tx_full stores tx_data. tx_wr && tx_full drops the data and sets tx_ovf.
- TX write when full with pop in the same cycle is accepted; count stays at depth.
- TX pop: pop && pndng advances the read pointer. pop && !pndng is ignored and sets pop_err.
- TX pop when empty with tx_wr in the same cycle: the write proceeds and the pop is ignored, setting pop_err.
- RX: push && !rx_full stores D_push. push && rx_full drops the packet, sets rx_ovf and increments rx_drop_cnt.
- Simultaneous push and rx_rd while full is accepted.
- rx_rd while empty is ignored, with no flag.
- Destination check on every accepted push: dest = D_push[pckg_sz-1 -: 8]. If dest != id and dest != broadcast, the packet is still stored and addr_err is set.
- Count arithmetic: count_next = count + wr_ok - rd_ok, where wr_ok and rd_ok are the qualified strobes above. Pointers are $clog2(depth) bits and wrap naturally (depth is a power of two).
- err_clr takes precedence over a same-cycle set of any sticky flag: the flag reads 0 the next cycle.
- No combinational path from pop to pndng/D_pop; both derive from registered state.

Decomposition:
- Package bus_pkg holds:
  - typedef dev_id_t (logic [7:0]);
  - localparam BROADCAST_ID = 8'hFF;
  - function dest_of(pkt), returning the top 8 bits;
  - localparam CNT_W helper via $clog2(depth+1).
- Sub-module sync_fifo_fwft (params width, depth), instantiated twice (TX, RX). It provides wr, rd, din, dout, count, full, empty, and dropped-write/dropped-read pulses.
- The top level adds the sticky flags, the destination check and the drop counter.

Test Plan:
- Reset, then 3 tx_wr of 16'h01AA, 16'h02BB, 16'h03CC -> next cycle pndng=1, D_pop=16'h01AA. After 3 pops D_pop sequence is AA, BB, CC; pndng=0 and tx_count=0.
- 9 tx_wr with no pop (depth 8) -> tx_full=1 after the 8th, tx_ovf=1, the 9th packet is lost; a 9th pop sets pop_err.
- RX full (8 pushes, id=0, dest 8'h00) then push + rx_rd in the same cycle -> accepted, rx_count stays 8. One further push without rx_rd -> rx_drop_cnt=1, rx_ovf=1.
- push D_push=16'hFF12 and 16'h0534 with id=0 -> both stored; addr_err=1 only after the second. err_clr -> addr_err=0, rx_drop_cnt=0.
- Assert reset asynchronously mid-stream with tx_count=5 and rx_count=3 -> pndng, rx_vld and the counts go to 0 without a clock edge. After release, a fresh write appears on D_pop after 1 cycle.
- Integrate 4 instances (ids 0..3) with bs_gnrtr_n_rbtr, drvrs=4, pckg_sz=16. Port 1 sends 16'h03AB -> port 3 rx_data=16'h03AB with no addr_err. A 16'hFF55 broadcast -> arrives at the other ports.
